// File: rtl/bus_datapath_pkg.sv
// Shared types for the bus datapath execute core: op codes, sequencer
// states and the op-code legality helper.
package bus_datapath_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SRA   = 4'd7,
    OP_ROL   = 4'd8,
    OP_ROR   = 4'd9,
    OP_NOT   = 4'd10,
    OP_NEG   = 4'd11,
    OP_MUL   = 4'd12,
    OP_ILL13 = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    T_Y,
    T_Z,
    T_WL,
    T_WH
  } state_e;

  function automatic logic op_legal(input op_e o);
    return (o <= OP_MUL);
  endfunction

endpackage

// File: rtl/bus_datapath_alu.sv
// Combinational ALU for the bus datapath: (Y, B, op) -> 2*DATA_W result.
// Non-MUL results are zero-extended; illegal ops yield 0.
module bus_datapath_alu
  import bus_datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   y,
  input  logic [DATA_W-1:0]   b,
  input  op_e                 op,
  output logic [2*DATA_W-1:0] result
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   low;
  logic [2*DATA_W-1:0] ys;
  logic [2*DATA_W-1:0] bs;
  logic [2*DATA_W-1:0] prod;

  // Operation select; rotates rely on a shift by DATA_W producing zero when sh is 0
  always_comb begin
    sh   = b[SH_W-1:0];
    ys   = {{DATA_W{y[DATA_W-1]}}, y};
    bs   = {{DATA_W{b[DATA_W-1]}}, b};
    prod = ys * bs;
    low  = '0;
    case (op)
      OP_ADD:  low = y + b;
      OP_SUB:  low = y - b;
      OP_AND:  low = y & b;
      OP_OR:   low = y | b;
      OP_XOR:  low = y ^ b;
      OP_SHL:  low = y << sh;
      OP_SHR:  low = y >> sh;
      OP_SRA:  low = $signed(y) >>> sh;
      OP_ROL:  low = (y << sh) | (y >> (DATA_W - sh));
      OP_ROR:  low = (y >> sh) | (y << (DATA_W - sh));
      OP_NOT:  low = ~b;
      OP_NEG:  low = '0 - b;
      default: low = '0;
    endcase
    result = (op == OP_MUL) ? prod : {{DATA_W{1'b0}}, low};
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus execute core: register file, Y/Z/HI/LO registers and a
// micro-step sequencer running Ra <= Rb op Rc per start request.
// Optional macro BUS_DATAPATH_R0_ZERO_EN: R0 reads as zero, writes to it dropped.
module bus_datapath_seq
  import bus_datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state;
  op_e                 op_q;
  logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   y_q;
  logic [2*DATA_W-1:0] z_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_res;
  logic                wr_en;
  logic [REG_AW-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  function automatic logic [DATA_W-1:0] reg_read(input logic [REG_AW-1:0] a);
`ifdef BUS_DATAPATH_R0_ZERO_EN
    if (a == '0) return '0;
`endif
    return regs[a];
  endfunction

  assign rd_data = reg_read(rd_addr);
  assign hi      = hi_q;
  assign lo      = lo_q;

  bus_datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .y      (y_q),
    .b      (bus),
    .op     (op_q),
    .result (alu_res)
  );

  // Bus source for the current micro-step
  always_comb begin
    case (state)
      T_Y:     bus = reg_read(rb_q);
      T_Z:     bus = reg_read(rc_q);
      T_WL:    bus = z_q[DATA_W-1:0];
      T_WH:    bus = z_q[2*DATA_W-1:DATA_W];
      default: bus = '0;
    endcase
  end

  // Register-file write port: sequencer writeback, else idle-only preload
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ld_addr;
    wr_data = ld_data;
    if (state == T_WL && op_q != OP_MUL && op_legal(op_q)) begin
      wr_en   = 1'b1;
      wr_addr = ra_q;
      wr_data = bus;
    end else if (state == IDLE && ld_en) begin
      wr_en = 1'b1;
    end
`ifdef BUS_DATAPATH_R0_ZERO_EN
    if (wr_addr == '0) wr_en = 1'b0;
`endif
  end

  // Register file storage
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Micro-step sequencer with registered busy/done/err
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      op_q  <= OP_ADD;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            ra_q  <= ra;
            rb_q  <= rb;
            rc_q  <= rc;
            busy  <= 1'b1;
            state <= T_Y;
          end
        end
        T_Y: begin
          y_q   <= bus;
          state <= T_Z;
        end
        T_Z: begin
          z_q   <= alu_res;
          state <= T_WL;
        end
        T_WL: begin
          if (op_q == OP_MUL) begin
            lo_q  <= bus;
            state <= T_WH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= ~op_legal(op_q);
            state <= IDLE;
          end
        end
        T_WH: begin
          hi_q  <= bus;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed testbench for bus_datapath_seq (DATA_W=32, NUM_REGS=16).
// Expected values follow BUS_DATAPATH_R0_ZERO_EN when the bench is built with it.
module tb_bus_datapath_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data, hi, lo;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  o;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [12];

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, {32'h0, rd_data}, {32'h0, exp});
  endtask

  // Issue one instruction and wait (bounded) for done; lat counts edges after the start edge
  task automatic run_op(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, output int lat, output logic e);
    op = o; ra = a; rb = b; rc = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    e = err;
  endtask

  initial begin
    int lat;
    int bc;
    logic e;
    logic seen_done;

    vecs = '{
      '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
      '{4'd9,  32'h0000_000F, 32'h0000_0024, 32'hF000_0000},
      '{4'd7,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF},
      '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
      '{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
      '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
      '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
      '{4'd5,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006},
      '{4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
      '{4'd8,  32'h8000_0001, 32'h0000_0001, 32'h0000_0003},
      '{4'd10, 32'h0000_1234, 32'h0000_FFFF, 32'hFFFF_0000},
      '{4'd11, 32'h0000_1234, 32'h0000_0001, 32'hFFFF_FFFF}
    };

    // Reset state
    #12;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_err",  {63'h0, err},  64'h0);
    check("rst_hi",   {32'h0, hi},   64'h0);
    check("rst_lo",   {32'h0, lo},   64'h0);
    clear = 1'b0;
    tick();
    check_reg("rst_r3", 4'd3, 32'h0);

    // ADD R3 = R1 + R2, cycle-by-cycle
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    op = 4'd0; ra = 4'd3; rb = 4'd1; rc = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    bc += int'(busy);
    check("add_e0_done", {63'h0, done}, 64'h0);
    tick();
    bc += int'(busy);
    check("add_e1_done", {63'h0, done}, 64'h0);
    tick();
    bc += int'(busy);
    check_reg("add_e2_r3", 4'd3, 32'h0);
    tick();
    check("add_e3_done", {63'h0, done}, 64'h1);
    check("add_e3_busy", {63'h0, busy}, 64'h0);
    check("add_e3_err",  {63'h0, err},  64'h0);
    check_reg("add_r3", 4'd3, 32'd12);
    check("add_busy_cycles", 64'(bc), 64'd3);
    tick();
    check("add_done_pulse", {63'h0, done}, 64'h0);

    // MUL
    load(4'd4, 32'h0001_0000);
    load(4'd5, 32'h0003_0000);
    run_op(4'd12, 4'd8, 4'd4, 4'd5, lat, e);
    check("mul1_lat", 64'(lat), 64'd4);
    check("mul1_hi", {32'h0, hi}, 64'h0000_0003);
    check("mul1_lo", {32'h0, lo}, 64'h0000_0000);
    check_reg("mul1_r8", 4'd8, 32'h0);
    load(4'd6, 32'hFFFF_FFFF);
    load(4'd7, 32'd2);
    run_op(4'd12, 4'd8, 4'd6, 4'd7, lat, e);
    check("mul2_lat", 64'(lat), 64'd4);
    check("mul2_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    check("mul2_lo", {32'h0, lo}, 64'hFFFF_FFFE);

    // ALU vector table: R12 = R1 op R2
    for (int i = 0; i < 12; i++) begin
      load(4'd1, vecs[i].b);
      load(4'd2, vecs[i].c);
      run_op(vecs[i].o, 4'd12, 4'd1, 4'd2, lat, e);
      check($sformatf("alu%0d_lat", i), 64'(lat), 64'd3);
      check($sformatf("alu%0d_err", i), {63'h0, e}, 64'h0);
      check_reg($sformatf("alu%0d_res", i), 4'd12, vecs[i].e);
    end

    // ra == rb == rc
    load(4'd5, 32'd3);
    run_op(4'd0, 4'd5, 4'd5, 4'd5, lat, e);
    check_reg("same_reg", 4'd5, 32'd6);

    // start and ld_en while busy are ignored; start in the done cycle is accepted
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    op = 4'd0; ra = 4'd13; rb = 4'd1; rc = 4'd2; start = 1'b1;
    tick();
    op = 4'd1; ra = 4'd14;
    ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'h99;
    tick();
    ld_en = 1'b0;
    check("ign_e1_done", {63'h0, done}, 64'h0);
    tick();
    check("ign_e2_done", {63'h0, done}, 64'h0);
    start = 1'b0;
    tick();
    check("ign_e3_done", {63'h0, done}, 64'h1);
    check_reg("ign_r13", 4'd13, 32'd12);
    check_reg("ign_r1", 4'd1, 32'd5);
    check_reg("ign_r14", 4'd14, 32'd0);
    run_op(4'd1, 4'd14, 4'd2, 4'd1, lat, e);
    check("b2b_lat", 64'(lat), 64'd3);
    check_reg("b2b_r14", 4'd14, 32'd2);

    // Illegal op: err with done, no write
    run_op(4'd13, 4'd15, 4'd1, 4'd2, lat, e);
    check("ill_lat", 64'(lat), 64'd3);
    check("ill_err", {63'h0, e}, 64'h1);
    check_reg("ill_r15", 4'd15, 32'd0);
    tick();
    check("ill_err_pulse", {63'h0, err}, 64'h0);

    // R0 behaviour
    load(4'd0, 32'h55);
    load(4'd2, 32'd9);
    run_op(4'd0, 4'd1, 4'd0, 4'd2, lat, e);
`ifdef BUS_DATAPATH_R0_ZERO_EN
    check_reg("r0_add", 4'd1, 32'd9);
    check_reg("r0_read", 4'd0, 32'd0);
`else
    check_reg("r0_add", 4'd1, 32'h5E);
    check_reg("r0_read", 4'd0, 32'h55);
`endif

    // clear during a MUL aborts everything
    load(4'd4, 32'h0001_0000);
    load(4'd5, 32'h0003_0000);
    op = 4'd12; ra = 4'd8; rb = 4'd4; rc = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    #2;
    clear = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_done = seen_done | done;
    end
    check("clr_no_done", {63'h0, seen_done}, 64'h0);
    check("clr_busy", {63'h0, busy}, 64'h0);
    check("clr_hi", {32'h0, hi}, 64'h0);
    check("clr_lo", {32'h0, lo}, 64'h0);
    check_reg("clr_r4", 4'd4, 32'h0);
    check_reg("clr_r1", 4'd1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
